// File: rtl/system_timer_sequencer_if.sv
// Avalon-MM bus between the time-of-day sequencer (master) and the interval-timer slave.
interface system_timer_sequencer_if;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic [15:0] tmr_readdata;
    logic        tmr_irq;

    modport master (
        output tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
        input  tmr_readdata, tmr_irq
    );

    modport slave (
        input  tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
        output tmr_readdata, tmr_irq
    );
endinterface

// File: rtl/system_timer_sequencer.sv
// Interval-timer owner: programs the timer, services timeouts, keeps hh:mm:ss and raises the alarm.
// Optional snooze re-trigger enabled by defining SYSTEM_TIMER_SEQ_SNOOZE_EN.
module system_timer_sequencer #(
`ifdef SYSTEM_TIMER_SEQ_SNOOZE_EN
    parameter int unsigned SNOOZE_MIN = 5,
`endif
    parameter logic [15:0] PERIOD_L = 16'hF07F,
    parameter logic [15:0] PERIOD_H = 16'h02FA,
    localparam int unsigned HOUR_W  = 5,
    localparam int unsigned MS_W    = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    system_timer_sequencer_if.master tmr,
    input  logic                     set_valid,
    output logic                     set_ready,
    input  logic [HOUR_W-1:0]        set_hour,
    input  logic [MS_W-1:0]          set_min,
    input  logic [MS_W-1:0]          set_sec,
    input  logic                     alarm_on,
    input  logic [HOUR_W-1:0]        alarm_hour,
    input  logic [MS_W-1:0]          alarm_min,
`ifdef SYSTEM_TIMER_SEQ_SNOOZE_EN
    input  logic                     snooze,
`endif
    output logic [HOUR_W-1:0]        hour,
    output logic [MS_W-1:0]          minute,
    output logic [MS_W-1:0]          second,
    output logic                     tick,
    output logic                     alarm
);

    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned DATA_W   = 16;
    localparam logic [ADDR_W-1:0] ADDR_STAT = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_CTL  = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_PL   = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_PH   = 3'd3;
    localparam logic [DATA_W-1:0] CTL_ITO   = 16'h0001;
    localparam logic [HOUR_W-1:0] HOUR_MAX  = 5'd23;
    localparam logic [MS_W-1:0]   MS_MAX    = 6'd59;

    typedef enum logic [2:0] {
        INIT_PL, INIT_PH, INIT_CTL, IDLE, RD, CHK, CLR, UPD
    } state_t;

    state_t              state, state_nxt;
    logic                init_hold;
    logic                set_accept_c;
    logic [ADDR_W-1:0]   addr_nxt;
    logic                cs_nxt;
    logic                wn_nxt;
    logic [DATA_W-1:0]   wd_nxt;
    logic [HOUR_W-1:0]   nxt_hour;
    logic [MS_W-1:0]     nxt_min;
    logic [MS_W-1:0]     nxt_sec;
    logic [HOUR_W-1:0]   ld_hour;
    logic [MS_W-1:0]     ld_min;
    logic [MS_W-1:0]     ld_sec;
    logic                alarm_hit_c;
    logic                unused_readdata;

    assign unused_readdata = ^tmr.tmr_readdata[DATA_W-1:1];

    // init_hold keeps the bus idle for the first cycle after reset before INIT_PL writes
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT_PL;
            init_hold <= 1'b1;
        end else begin
            state     <= state_nxt;
            init_hold <= 1'b0;
        end
    end

    // Next state, then bus cycle decoded from the state being entered
    always_comb begin
        state_nxt    = state;
        set_accept_c = 1'b0;
        addr_nxt     = '0;
        cs_nxt       = 1'b0;
        wn_nxt       = 1'b1;
        wd_nxt       = '0;
        case (state)
            INIT_PL:  state_nxt = init_hold ? INIT_PL : INIT_PH;
            INIT_PH:  state_nxt = INIT_CTL;
            INIT_CTL: state_nxt = IDLE;
            IDLE: begin
                if (set_valid) begin
                    set_accept_c = 1'b1;
                    state_nxt    = INIT_PL;
                end else if (tmr.tmr_irq) begin
                    state_nxt = RD;
                end
            end
            RD:       state_nxt = CHK;
            CHK:      state_nxt = tmr.tmr_readdata[0] ? CLR : IDLE;
            CLR:      state_nxt = UPD;
            UPD:      state_nxt = IDLE;
            default:  state_nxt = INIT_PL;
        endcase
        case (state_nxt)
            INIT_PL:  begin cs_nxt = 1'b1; wn_nxt = 1'b0; addr_nxt = ADDR_PL;  wd_nxt = PERIOD_L; end
            INIT_PH:  begin cs_nxt = 1'b1; wn_nxt = 1'b0; addr_nxt = ADDR_PH;  wd_nxt = PERIOD_H; end
            INIT_CTL: begin cs_nxt = 1'b1; wn_nxt = 1'b0; addr_nxt = ADDR_CTL; wd_nxt = CTL_ITO;  end
            RD:       begin cs_nxt = 1'b1; addr_nxt = ADDR_STAT; end
            CLR:      begin cs_nxt = 1'b1; wn_nxt = 1'b0; addr_nxt = ADDR_STAT; end
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmr.tmr_address    <= '0;
            tmr.tmr_chipselect <= 1'b0;
            tmr.tmr_write_n    <= 1'b1;
            tmr.tmr_writedata  <= '0;
            set_ready          <= 1'b0;
        end else begin
            tmr.tmr_address    <= addr_nxt;
            tmr.tmr_chipselect <= cs_nxt;
            tmr.tmr_write_n    <= wn_nxt;
            tmr.tmr_writedata  <= wd_nxt;
            set_ready          <= (state_nxt == IDLE);
        end
    end

    // One-second advance with minute/hour/day carry
    always_comb begin
        nxt_sec  = (second == MS_MAX) ? '0 : second + MS_W'(1);
        nxt_min  = minute;
        nxt_hour = hour;
        if (second == MS_MAX) begin
            nxt_min = (minute == MS_MAX) ? '0 : minute + MS_W'(1);
            if (minute == MS_MAX)
                nxt_hour = (hour == HOUR_MAX) ? '0 : hour + HOUR_W'(1);
        end
    end

    assign ld_hour = (set_hour > HOUR_MAX) ? '0 : set_hour;
    assign ld_min  = (set_min  > MS_MAX)   ? '0 : set_min;
    assign ld_sec  = (set_sec  > MS_MAX)   ? '0 : set_sec;

`ifdef SYSTEM_TIMER_SEQ_SNOOZE_EN
    logic [HOUR_W-1:0] snz_hour, tgt_hour;
    logic [MS_W-1:0]   snz_min, tgt_min;
    logic [MS_W:0]     min_sum;
    logic              snz_armed;
    logic              snz_hit_c;

    // Snooze target = now + SNOOZE_MIN minutes, wrapping hour and day
    always_comb begin
        min_sum  = (MS_W+1)'(minute) + (MS_W+1)'(SNOOZE_MIN);
        tgt_min  = MS_W'(min_sum);
        tgt_hour = hour;
        if (min_sum > (MS_W+1)'(MS_MAX)) begin
            tgt_min  = MS_W'(min_sum - (MS_W+1)'(60));
            tgt_hour = (hour == HOUR_MAX) ? '0 : hour + HOUR_W'(1);
        end
    end

    assign snz_hit_c = snz_armed && (nxt_hour == snz_hour) && (nxt_min == snz_min) &&
                       (nxt_sec == '0);

    always_ff @(posedge clk) begin
        if (reset || set_accept_c) begin
            snz_armed <= 1'b0;
            snz_hour  <= '0;
            snz_min   <= '0;
        end else if (snooze) begin
            snz_armed <= 1'b1;
            snz_hour  <= tgt_hour;
            snz_min   <= tgt_min;
        end else if (state_nxt == UPD && alarm_on && snz_hit_c) begin
            snz_armed <= 1'b0;
        end
    end

    assign alarm_hit_c = alarm_on && (((nxt_hour == alarm_hour) && (nxt_min == alarm_min) &&
                                       (nxt_sec == '0)) || snz_hit_c);
`else
    assign alarm_hit_c = alarm_on && (nxt_hour == alarm_hour) && (nxt_min == alarm_min) &&
                         (nxt_sec == '0);
`endif

    // Time-of-day, tick and alarm all change on entry to UPD so they are visible during it
    always_ff @(posedge clk) begin
        if (reset) begin
            hour   <= '0;
            minute <= '0;
            second <= '0;
            tick   <= 1'b0;
            alarm  <= 1'b0;
        end else begin
            tick  <= (state_nxt == UPD);
            alarm <= (state_nxt == UPD) && alarm_hit_c;
            if (set_accept_c) begin
                hour   <= ld_hour;
                minute <= ld_min;
                second <= ld_sec;
            end else if (state_nxt == UPD) begin
                hour   <= nxt_hour;
                minute <= nxt_min;
                second <= nxt_sec;
            end
        end
    end

endmodule

// File: tb/tb_system_timer_sequencer.sv
// Scoreboard bench: expected bus cycles and ticks are queued by the stimulus and popped by a monitor.
module tb_system_timer_sequencer;

    typedef struct packed {
        logic        is_tick;
        logic [2:0]  addr;
        logic        wr;
        logic [15:0] data;
        logic [4:0]  h;
        logic [5:0]  m;
        logic [5:0]  s;
        logic        al;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       set_valid, set_ready;
    logic [4:0] set_hour, alarm_hour, hour;
    logic [5:0] set_min, set_sec, alarm_min, minute, second;
    logic       alarm_on, tick, alarm;
`ifdef SYSTEM_TIMER_SEQ_SNOOZE_EN
    logic       snooze;
`endif
    logic       fire, spur;
    logic       to_flag = 1'b0;
    int         cyc = 0;
    int         last_tick_cyc = 0;
    int         total = 0;
    int         bad = 0;
    ev_t        exp_q[$];

    system_timer_sequencer_if tmr_if ();

    system_timer_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .tmr        (tmr_if),
        .set_valid  (set_valid),
        .set_ready  (set_ready),
        .set_hour   (set_hour),
        .set_min    (set_min),
        .set_sec    (set_sec),
        .alarm_on   (alarm_on),
        .alarm_hour (alarm_hour),
        .alarm_min  (alarm_min),
`ifdef SYSTEM_TIMER_SEQ_SNOOZE_EN
        .snooze     (snooze),
`endif
        .hour       (hour),
        .minute     (minute),
        .second     (second),
        .tick       (tick),
        .alarm      (alarm)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Timer slave model: TO flag set by fire, cleared by any write to status
    always @(posedge clk) begin
        if (tmr_if.tmr_chipselect && !tmr_if.tmr_write_n && tmr_if.tmr_address == 3'd0)
            to_flag <= 1'b0;
        else if (fire)
            to_flag <= 1'b1;
        tmr_if.tmr_readdata <= {15'b0, to_flag};
    end
    assign tmr_if.tmr_irq = to_flag | spur;

    function automatic ev_t bus_ev(input logic [2:0] a, input logic w, input logic [15:0] d);
        ev_t e;
        e = '0; e.addr = a; e.wr = w; e.data = d;
        return e;
    endfunction

    function automatic ev_t tick_ev(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                                    input logic al);
        ev_t e;
        e = '0; e.is_tick = 1'b1; e.h = h; e.m = m; e.s = s; e.al = al;
        return e;
    endfunction

    task automatic monitor();
        ev_t e, got;
        forever begin
            @(negedge clk);
            if (tmr_if.tmr_chipselect) begin
                got = bus_ev(tmr_if.tmr_address, !tmr_if.tmr_write_n, tmr_if.tmr_writedata);
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL bus_unexpected: got addr=%0d wr=%0b data=%h want no access",
                             got.addr, got.wr, got.data);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        bad++;
                        $display("FAIL bus_cycle: got addr=%0d wr=%0b data=%h want tick=%0b addr=%0d wr=%0b data=%h",
                                 got.addr, got.wr, got.data, e.is_tick, e.addr, e.wr, e.data);
                    end
                end
            end
            if (tick) begin
                got = tick_ev(hour, minute, second, alarm);
                last_tick_cyc = cyc;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL tick_unexpected: got %0d:%0d:%0d alarm=%0b want no tick",
                             got.h, got.m, got.s, got.al);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        bad++;
                        $display("FAIL tick_event: got %0d:%0d:%0d alarm=%0b want tick=%0b %0d:%0d:%0d alarm=%0b",
                                 got.h, got.m, got.s, got.al, e.is_tick, e.h, e.m, e.s, e.al);
                    end
                end
            end else if (alarm) begin
                total++;
                bad++;
                $display("FAIL alarm_without_tick: got alarm=1 want 0");
            end
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_time(input string nm, input int h, input int m, input int s);
        total++;
        if (int'(hour) != h || int'(minute) != m || int'(second) != s) begin
            bad++;
            $display("FAIL %s: got %0d:%0d:%0d want %0d:%0d:%0d", nm, hour, minute, second, h, m, s);
        end
    endtask

    task automatic push_init();
        exp_q.push_back(bus_ev(3'd2, 1'b1, 16'hF07F));
        exp_q.push_back(bus_ev(3'd3, 1'b1, 16'h02FA));
        exp_q.push_back(bus_ev(3'd1, 1'b1, 16'h0001));
    endtask

    task automatic push_service(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                                input logic al);
        exp_q.push_back(bus_ev(3'd0, 1'b0, 16'h0000));
        exp_q.push_back(bus_ev(3'd0, 1'b1, 16'h0000));
        exp_q.push_back(tick_ev(h, m, s, al));
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        @(negedge clk);
        while (!set_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!set_ready) begin
            total++;
            bad++;
            $display("FAIL %s_ready_timeout: got set_ready=0 want 1", nm);
        end
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_drain: got %0d pending events want 0", nm, exp_q.size());
            exp_q.delete();
        end
        wait_ready(nm);
    endtask

    task automatic timeout_pulse(output int c0);
        @(posedge clk); #1 fire = 1'b1;
        @(posedge clk); #1 fire = 1'b0;
        c0 = cyc;
    endtask

    task automatic do_set(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        wait_ready("set");
        push_init();
        set_hour  = h;
        set_min   = m;
        set_sec   = s;
        set_valid = 1'b1;
        @(posedge clk); #1 set_valid = 1'b0;
    endtask

    initial begin
        int c0;
        int n;
        reset = 1'b1; set_valid = 1'b0; set_hour = '0; set_min = '0; set_sec = '0;
        alarm_on = 1'b0; alarm_hour = '0; alarm_min = '0; fire = 1'b0; spur = 1'b0;
`ifdef SYSTEM_TIMER_SEQ_SNOOZE_EN
        snooze = 1'b0;
`endif
        fork monitor(); join_none

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_chipselect", int'(tmr_if.tmr_chipselect), 0);
        chk("rst_write_n", int'(tmr_if.tmr_write_n), 1);
        chk("rst_address", int'(tmr_if.tmr_address), 0);
        chk("rst_writedata", int'(tmr_if.tmr_writedata), 0);
        chk("rst_set_ready", int'(set_ready), 0);
        chk("rst_tick_alarm", int'({tick, alarm}), 0);
        chk_time("rst_time", 0, 0, 0);
        push_init();
        reset = 1'b0;
        drain("init");
        chk("init_set_ready", int'(set_ready), 1);
        chk_time("init_time", 0, 0, 0);

        // First timeout and service latency
        push_service(5'd0, 6'd0, 6'd1, 1'b0);
        timeout_pulse(c0);
        drain("svc1");
        chk("svc_latency", last_tick_cyc - c0, 4);

        // Full-day wrap
        do_set(5'd23, 6'd59, 6'd59);
        chk_time("set_235959", 23, 59, 59);
        drain("set_wrap");
        push_service(5'd0, 6'd0, 6'd0, 1'b0);
        timeout_pulse(c0);
        drain("svc_wrap");

        // Out-of-range hour and minute load as zero
        do_set(5'd25, 6'd61, 6'd10);
        chk_time("set_clamp", 0, 0, 10);
        drain("set_clamp");

        // Alarm armed
        alarm_on = 1'b1; alarm_hour = 5'd7; alarm_min = 6'd30;
        do_set(5'd7, 6'd29, 6'd59);
        drain("set_alarm");
        push_service(5'd7, 6'd30, 6'd0, 1'b1);
        timeout_pulse(c0);
        drain("svc_alarm");

        // Alarm disarmed
        alarm_on = 1'b0;
        do_set(5'd7, 6'd29, 6'd59);
        drain("set_noalarm");
        push_service(5'd7, 6'd30, 6'd0, 1'b0);
        timeout_pulse(c0);
        drain("svc_noalarm");

        // Spurious irq: read only, no clear, no tick
        wait_ready("spur");
        exp_q.push_back(bus_ev(3'd0, 1'b0, 16'h0000));
        @(posedge clk); #1 spur = 1'b1;
        c0 = cyc;
        @(posedge clk); #1 spur = 1'b0;
        n = 0;
        @(negedge clk);
        while (!set_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("spur_idle_return", cyc - c0, 3);
        repeat (3) @(negedge clk);
        chk_time("spur_time", 7, 30, 0);
        chk("spur_pending", exp_q.size(), 0);

        // Set and irq in the same IDLE cycle: set wins, irq serviced after re-init
        wait_ready("setirq");
        push_init();
        push_service(5'd12, 6'd0, 6'd1, 1'b0);
        @(posedge clk); #1 fire = 1'b1;
        @(posedge clk); #1 fire = 1'b0;
        set_hour = 5'd12; set_min = 6'd0; set_sec = 6'd0; set_valid = 1'b1;
        @(posedge clk); #1 set_valid = 1'b0;
        chk_time("setirq_load", 12, 0, 0);
        drain("setirq");

        // Reset during CLR aborts the service and restarts init
        exp_q.push_back(bus_ev(3'd0, 1'b0, 16'h0000));
        exp_q.push_back(bus_ev(3'd0, 1'b1, 16'h0000));
        push_init();
        timeout_pulse(c0);
        n = 0;
        @(negedge clk);
        while (!(tmr_if.tmr_chipselect && !tmr_if.tmr_write_n && tmr_if.tmr_address == 3'd0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("clr_reached", int'(tmr_if.tmr_chipselect && !tmr_if.tmr_write_n), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_chipselect", int'(tmr_if.tmr_chipselect), 0);
        chk("abort_write_n", int'(tmr_if.tmr_write_n), 1);
        chk("abort_set_ready", int'(set_ready), 0);
        chk_time("abort_time", 0, 0, 0);
        reset = 1'b0;
        drain("reinit");
        chk_time("reinit_time", 0, 0, 0);

        repeat (5) @(negedge clk);
        chk("final_pending", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/system_timer_sequencer.md
Name: system_timer_sequencer

Overview:
- Avalon-MM master that owns the interval-timer peripheral (`system_TIMER`-style slave: 3-bit address, 16-bit data, registered readdata, level irq).
- On reset it configures the timer's period and interrupt enable.
- It services each timeout interrupt: read status, confirm TO, clear status.
- It keeps hh:mm:ss time-of-day, fires the alarm pulse and accepts a time-set handshake from the alarm-clock UI logic.

Parameters:
- PERIOD_L, 16'hF07F, low half of timer period, written to timer address 2
- PERIOD_H, 16'h02FA, high half of timer period, written to timer address 3
- SNOOZE_MIN, 5, minutes added on snooze (only with the optional feature)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tmr_address  out  3  timer slave address
- tmr_chipselect  out  1  timer chipselect
- tmr_write_n  out  1  timer write strobe, active-low
- tmr_writedata  out  16  timer write data
- tmr_readdata  in  16  timer read data, valid one cycle after the address is presented
- tmr_irq  in  1  timer interrupt, level
- set_valid  in  1  time-set request
- set_ready  out  1  sequencer can accept a set
- set_hour  in  5  new hour
- set_min  in  6  new minute
- set_sec  in  6  new second
- alarm_on  in  1  alarm armed
- alarm_hour  in  5  alarm hour
- alarm_min  in  6  alarm minute
- hour  out  5  current hour, 0-23
- minute  out  6  current minute, 0-59
- second  out  6  current second, 0-59
- tick  out  1  one-cycle pulse per serviced timeout
- alarm  out  1  one-cycle alarm pulse

Behaviour:
- Clock, reset and clock-enable:
  - Single clock clk.
  - reset is synchronous, active-high.
  - Internally there is no clock-enable; every state lasts exactly one cycle.
- Reset values:
  - State INIT_PL.
  - hour/minute/second = 0; tick = 0; alarm = 0; set_ready = 0.
  - Bus idle: tmr_chipselect = 0, tmr_write_n = 1, tmr_address = 0, tmr_writedata = 0.
- Reset asserted mid-operation (including mid bus access) aborts the access next edge and re-runs init.
- Bus outputs decode from the state register only; there are no combinational input-to-output paths. Idle bus values apply in every state not listed below.
- FSM states:
  - INIT_PL: write addr 2 = PERIOD_L -> INIT_PH.
  - INIT_PH: write addr 3 = PERIOD_H -> INIT_CTL.
  - INIT_CTL: write addr 1 = 16'h0001 (interrupt enable) -> IDLE.
  - IDLE: set_ready = 1, bus idle.
    - If set_valid: load time -> INIT_PL. Re-writing the period forces the timer to reload, so the new second starts from a full period.
    - Else if tmr_irq -> RD.
    - set has priority over tmr_irq in the same cycle. The irq stays pending and is serviced after re-init.
  - RD: chipselect = 1, write_n = 1, address = 0 -> CHK.
  - CHK: sample tmr_readdata[0] (TO bit).
    - 1 -> CLR.
    - 0 -> IDLE (spurious irq: no write, no tick).
  - CLR: write addr 0 = 16'h0000 (clears TO; irq drops one cycle later) -> UPD.
  - UPD: advance time, pulse tick -> IDLE.
- Service latency: irq seen in IDLE to tick = 4 cycles (RD, CHK, CLR, UPD).
- Time arithmetic:
  - second 59 -> 0 with minute+1.
  - minute 59 -> 0 with hour+1.
  - hour 23 -> 0.
- Set loading: any out-of-range set field (hour > 23, min > 59, sec > 59) loads as 0; the other fields load normally.
- Alarm:
  - Evaluated in UPD on the new time.
  - alarm = 1 for one cycle when alarm_on, hour == alarm_hour, minute == alarm_min and second == 0.
  - Setting the time directly onto the alarm time does not fire.
  - alarm_on low suppresses the pulse.
- Timer-side corner case: a timeout coinciding with the CLR write is lost (the timer clears with priority). This is acceptable for periods much greater than 4 cycles.

Optional Feature:
- Macro: SYSTEM_TIMER_SEQ_SNOOZE_EN.
- With the macro:
  - Adds input port snooze (1 bit).
  - A snooze pulse in any state arms a snooze target = current hour:minute + SNOOZE_MIN minutes, with hour and day wrap.
  - In UPD, if the target is armed, the new time equals target:00 and alarm_on is set, alarm pulses and the target disarms.
  - A new snooze re-arms, overwriting the target.
  - reset and any accepted set disarm the target.
- Without the macro: no snooze port and no target logic; alarm fires only on alarm_hour:alarm_min.

Test Plan:
- Release reset -> three consecutive write cycles: addr 2 data F07F, addr 3 data 02FA, addr 1 data 0001; then set_ready = 1, time 00:00:00.
- tmr_irq = 1 with TO = 1 -> RD (addr 0 read), CHK, CLR (addr 0 write 0000), tick pulse; second 0 -> 1, tick 4 cycles after irq.
- Set 23:59:59 then one timeout -> 00:00:00. Set 25:61:10 -> loads 00:00:10.
- alarm_on = 1, alarm 07:30, set 07:29:59, one timeout -> alarm high exactly one cycle at 07:30:00. Repeat with alarm_on = 0 -> no alarm.
- tmr_irq = 1 with tmr_readdata[0] = 0 -> no write cycle, no tick, back in IDLE after 2 cycles.
- set_valid and tmr_irq in the same IDLE cycle -> set 12:00:00 accepted, init writes repeat, then irq serviced -> 12:00:01. Assert reset during CLR -> bus idle next cycle, init sequence restarts.
